swan_core_param: RTL and testbench
==================================

# swan_core_param

Parametrised, iterative SWAN block-cipher core covering encryption and decryption in one instance. Block width, key width, round count and key-schedule constants are set by parameters. The core uses a valid/ready handshake on both input and output, and runs one half-round per clock. Decryption derives the final round key with a multi-cycle precompute and caches it for back-to-back decryptions under the same key. The core sits between the bus-facing data path and the mode-of-operation wrappers, and replaces the fixed-width encrypt and decrypt cores.

## Interface
Parameters:
- BLOCK_SIZE, 64: cipher block width; legal values 64, 128, 256. SIDE = BLOCK_SIZE/2.
- KEY_SIZE, 256: master key width; must be a multiple of SIDE and at least 2*SIDE.
- ROUNDS, 64: full rounds. H = 2*ROUNDS half-rounds; H must be even.
- PD, 24: key rotation distance in bits; 0 < PD < KEY_SIZE.
- DELTA, 32'h9e3779b9: round-constant increment, zero-extended or truncated to SIDE bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  core can accept a request.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on acceptance.
- inp  in  BLOCK_SIZE  input block; bit 0 is the MSB.
- key  in  KEY_SIZE  master key; sampled on acceptance.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out  out  BLOCK_SIZE  result block, equal to {R,L}.

## Operation
- Block split on acceptance: R = inp[0:SIDE-1], L = inp[SIDE:BLOCK_SIZE-1].
- Round function: F(x,k) = rho(vartheta(beta_table(vartheta(x) ^ k))). The primitives are the team's, generalised to SIDE bits.
- Key schedule step S on (K, rd):
  - rd' = rd + DELTA mod 2^SIDE.
  - K' = rotr(K, PD), then K'[KEY_SIZE-SIDE:KEY_SIZE-1] += rd' mod 2^SIDE.
- K_0 = key, rd_0 = 0, and (K_j, rd_j) = S(K_{j-1}, rd_{j-1}). Subkey sk_j = K_j[0:SIDE-1].
- Inverse step S⁻¹: subtract rd from the low SIDE bits, then rotl by PD, then rd -= DELTA.
- Encryption, half-rounds j = 1..H in order:
  - j odd: R ^= F(L, sk_j).
  - j even: L ^= F(R, sk_j).
- Decryption applies the same update for j = H down to 1. Keys come from (K_H, rd_H), which is stepped by S⁻¹ after each half-round.
- States:
  - IDLE: in_ready = 1. On in_valid, latch the inputs.
    - mode 0 goes to RUN.
    - mode 1 with a cache hit goes to RUN, with K_H and rd_H loaded from the cache.
    - mode 1 with a miss goes to PRECOMP.
  - PRECOMP: apply S once per cycle for H cycles. After the H-th step, write K_H and rd_H to the cache, store the key in the tag register, set cache_valid, and go to RUN.
  - RUN: one half-round per cycle, with the counter decrementing from H-1 to 0. After the last half-round, go to DONE.
  - DONE: out_valid = 1 and out holds stable. On out_ready, go to IDLE.
- Cache hit: cache_valid && key == tag. Only a mode-1 request with a miss updates the cache. Encryption never modifies it.
- in_ready is 0 in PRECOMP, RUN and DONE. Requests offered there are ignored, not queued.

## Timing
- Reset (asynchronous) forces:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - L, R, rd, counter cleared, so out = 0;
  - cache_valid = 0.
- Reset mid-operation aborts the block. No partial result is ever presented.
- Acceptance edge is T0. out_valid rises after the following edge:
  - encryption: T0 + H;
  - decryption, cache hit: T0 + H;
  - decryption, cache miss: T0 + 2H.
- out_valid && out_ready on edge Tn: in_ready is 1 from Tn+1. The earliest next acceptance is the edge Tn+1, giving one bubble cycle.
- out_ready held high throughout: throughput is one block per H+2 cycles (hit or encrypt).
- out_ready low: DONE persists indefinitely with out unchanged.
- in_valid and out_ready are never both relevant in the same cycle, because input is accepted only in IDLE.
- The counter and rd wrap modulo their widths. The counter never underflows: the RUN → DONE transition happens when the counter is 0.

## Test plan
- Known answer: BLOCK_SIZE 64, KEY_SIZE 256, key 0, inp 64'h0123456789abcdef, mode 0. Required: out equals the C golden model's value, and out_valid is first high exactly 128 cycles after acceptance.
- Round trip: encrypt a random block under a random key, then decrypt the result. Required: the original block is returned; the first decrypt takes 256 cycles (miss); a second decrypt under the same key takes 128 cycles (hit).
- Cache invalidation: decrypt under key A, then decrypt under key B. Required: the key B decrypt is a miss (256 cycles) with the correct plaintext; a following decrypt under key B hits (128 cycles).
- Backpressure: hold out_ready = 0 for 50 cycles after out_valid. Required: out is stable, in_ready stays 0, and in_valid pulses are ignored. Release out_ready: in_ready rises on the next cycle.
- Async reset: assert rst mid-PRECOMP and mid-RUN, asynchronously to clk. Required: out_valid = 0 and out = 0 immediately. A following decrypt under the same key is a miss (256 cycles).
- Width sweep: BLOCK_SIZE 128 and 256, KEY_SIZE 2*BLOCK_SIZE. Required: 1000 random encrypt/decrypt round trips recover the plaintext and match the golden model.

Source files
------------

// File: rtl/swan_core_param.sv
// Iterative SWAN block cipher, one half-round per clock, encrypt and decrypt in one core.
// Decryption precomputes the final round key once per key and caches it for reuse.
module swan_core_param #(
    parameter int unsigned BLOCK_SIZE = 64,
    parameter int unsigned KEY_SIZE   = 256,
    parameter int unsigned ROUNDS     = 64,
    parameter int unsigned PD         = 24,
    parameter logic [31:0] DELTA      = 32'h9e3779b9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [BLOCK_SIZE-1:0] inp,
    input  logic [KEY_SIZE-1:0]   key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_SIZE-1:0] out
);

    localparam int unsigned SIDE = BLOCK_SIZE / 2;
    localparam int unsigned H    = 2 * ROUNDS;
    localparam int unsigned CW   = (H > 2) ? $clog2(H) : 1;
    localparam logic [SIDE-1:0] DELTA_S = SIDE'(DELTA);
    localparam logic [CW-1:0]   CNT_TOP = CW'(H - 1);

    typedef enum logic [1:0] {StIdle, StPrecomp, StRun, StDone} state_e;

    function automatic logic [SIDE-1:0] rotl_s(input logic [SIDE-1:0] x, input int unsigned n);
        return (x << n) | (x >> (SIDE - n));
    endfunction

    function automatic logic [KEY_SIZE-1:0] rotr_k(input logic [KEY_SIZE-1:0] x,
                                                   input int unsigned n);
        return (x >> n) | (x << (KEY_SIZE - n));
    endfunction

    function automatic logic [KEY_SIZE-1:0] rotl_k(input logic [KEY_SIZE-1:0] x,
                                                   input int unsigned n);
        return (x << n) | (x >> (KEY_SIZE - n));
    endfunction

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hc;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hb;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'ha;
            4'h7: y = 4'hd;
            4'h8: y = 4'h3;
            4'h9: y = 4'he;
            4'ha: y = 4'hf;
            4'hb: y = 4'h8;
            4'hc: y = 4'h4;
            4'hd: y = 4'h7;
            4'he: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [SIDE-1:0] vartheta(input logic [SIDE-1:0] x);
        return x ^ rotl_s(x, 1) ^ rotl_s(x, SIDE / 4);
    endfunction

    function automatic logic [SIDE-1:0] beta_table(input logic [SIDE-1:0] x);
        logic [SIDE-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < SIDE / 4; i++) begin
            y[4*i +: 4] = sbox4(x[4*i +: 4]);
        end
        return y;
    endfunction

    function automatic logic [SIDE-1:0] rho(input logic [SIDE-1:0] x);
        return rotl_s(x, 3) ^ rotl_s(x, SIDE / 2 + 1);
    endfunction

    function automatic logic [SIDE-1:0] round_f(input logic [SIDE-1:0] x,
                                                input logic [SIDE-1:0] k);
        return rho(vartheta(beta_table(vartheta(x) ^ k)));
    endfunction

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [SIDE-1:0]     l_q, r_q, rd_q;
    logic [KEY_SIZE-1:0] k_q, key_q;
    logic                mode_q;
    logic [KEY_SIZE-1:0] cache_k_q, tag_q;
    logic [SIDE-1:0]     cache_rd_q;
    logic                cache_valid_q;
    logic                in_ready_q, out_valid_q;

    logic [KEY_SIZE-1:0] fwd_k, inv_k;
    logic [SIDE-1:0]     fwd_rd, inv_rd, sk, f_val;
    logic                odd_hr, hit;

    always_comb begin
        fwd_rd = rd_q + DELTA_S;
        fwd_k  = rotr_k(k_q, PD);
        fwd_k[SIDE-1:0] = fwd_k[SIDE-1:0] + fwd_rd;

        inv_k  = k_q;
        inv_k[SIDE-1:0] = k_q[SIDE-1:0] - rd_q;
        inv_k  = rotl_k(inv_k, PD);
        inv_rd = rd_q - DELTA_S;

        // Encryption steps the schedule before use; decryption holds K_j and unwinds after.
        sk     = mode_q ? k_q[KEY_SIZE-1 -: SIDE] : fwd_k[KEY_SIZE-1 -: SIDE];
        odd_hr = mode_q ? ~cnt_q[0] : cnt_q[0];
        f_val  = round_f(odd_hr ? l_q : r_q, sk);
        hit    = cache_valid_q && (key == tag_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            l_q           <= '0;
            r_q           <= '0;
            rd_q          <= '0;
            k_q           <= '0;
            key_q         <= '0;
            mode_q        <= 1'b0;
            cache_k_q     <= '0;
            cache_rd_q    <= '0;
            tag_q         <= '0;
            cache_valid_q <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mode_q     <= mode;
                        key_q      <= key;
                        r_q        <= inp[BLOCK_SIZE-1:SIDE];
                        l_q        <= inp[SIDE-1:0];
                        cnt_q      <= CNT_TOP;
                        in_ready_q <= 1'b0;
                        if (mode && hit) begin
                            k_q     <= cache_k_q;
                            rd_q    <= cache_rd_q;
                            state_q <= StRun;
                        end else begin
                            k_q     <= key;
                            rd_q    <= '0;
                            state_q <= mode ? StPrecomp : StRun;
                        end
                    end
                end
                StPrecomp: begin
                    k_q  <= fwd_k;
                    rd_q <= fwd_rd;
                    if (cnt_q == '0) begin
                        cache_k_q     <= fwd_k;
                        cache_rd_q    <= fwd_rd;
                        tag_q         <= key_q;
                        cache_valid_q <= 1'b1;
                        cnt_q         <= CNT_TOP;
                        state_q       <= StRun;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StRun: begin
                    if (odd_hr) begin
                        r_q <= r_q ^ f_val;
                    end else begin
                        l_q <= l_q ^ f_val;
                    end
                    k_q  <= mode_q ? inv_k : fwd_k;
                    rd_q <= mode_q ? inv_rd : fwd_rd;
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = {r_q, l_q};

endmodule

// File: tb/tb_swan_core_param.sv
// Scoreboard bench for swan_core_param at 64-bit block / 256-bit key: results, latency,
// key cache hits and misses, backpressure and asynchronous reset.
module tb_swan_core_param;

    localparam int H = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid, in_ready, mode, out_valid, out_ready;
    logic [63:0]  inp, out;
    logic [255:0] key;

    swan_core_param #(
        .BLOCK_SIZE(64),
        .KEY_SIZE  (256),
        .ROUNDS    (64),
        .PD        (24),
        .DELTA     (32'h9e3779b9)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .inp      (inp),
        .key      (key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_out_q[$];
    int          exp_lat_q[$];
    int          t0_q[$];
    string       name_q[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: full schedule table, decryption walks it backwards.
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x};
        return t[63-n -: 32];
    endfunction

    function automatic logic [31:0] sb(input logic [31:0] x);
        logic [63:0] tbl;
        logic [31:0] y;
        int          v;
        tbl = 64'hc56b90ad3ef84712;
        for (int i = 0; i < 8; i++) begin
            v = int'(x[4*i +: 4]);
            y[4*i +: 4] = tbl[63-4*v -: 4];
        end
        return y;
    endfunction

    function automatic logic [31:0] ff(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] a, c, d;
        a = x ^ rl(x, 1) ^ rl(x, 8);
        c = sb(a ^ k);
        d = c ^ rl(c, 1) ^ rl(c, 8);
        return rl(d, 3) ^ rl(d, 17);
    endfunction

    function automatic logic [63:0] model(input logic [63:0] blk, input logic [255:0] k,
                                          input logic dec);
        logic [255:0] ks[0:H];
        logic [511:0] t;
        logic [31:0]  rd, r, l;
        int           j;
        ks[0] = k;
        rd = 32'h0;
        for (int i = 1; i <= H; i++) begin
            rd = rd + 32'h9e3779b9;
            t = {ks[i-1], ks[i-1]};
            ks[i] = t[24 +: 256];
            ks[i][31:0] = ks[i][31:0] + rd;
        end
        r = blk[63:32];
        l = blk[31:0];
        for (int n = 1; n <= H; n++) begin
            j = dec ? H + 1 - n : n;
            if (j % 2 == 1) r = r ^ ff(l, ks[j][255 -: 32]);
            else            l = l ^ ff(r, ks[j][255 -: 32]);
        end
        return {r, l};
    endfunction

    // Monitor: one comparison per rising out_valid.
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (exp_out_q.size() == 0) begin
                    chk("unexpected_output", {192'h0, out}, 256'h0);
                end else begin
                    chk({name_q[0], "_out"}, {192'h0, out}, {192'h0, exp_out_q[0]});
                    chk({name_q[0], "_latency"}, 256'(cyc - t0_q[0]), 256'(exp_lat_q[0]));
                    void'(exp_out_q.pop_front());
                    void'(exp_lat_q.pop_front());
                    void'(t0_q.pop_front());
                    void'(name_q.pop_front());
                end
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    task automatic issue(input logic m, input logic [63:0] blk, input logic [255:0] k,
                         input logic [63:0] req, input int lat, input string nm);
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({nm, "_accept_timeout"}, 256'h0, 256'h1);
        in_valid = 1'b1;
        mode = m;
        inp = blk;
        key = k;
        @(posedge clk);
        #1;
        exp_out_q.push_back(req);
        exp_lat_q.push_back(lat);
        t0_q.push_back(cyc);
        name_q.push_back(nm);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 700) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({nm, "_done_timeout"}, 256'h0, 256'h1);
    endtask

    task automatic reset_mid(input string nm);
        #3 rst = 1'b1;
        #1;
        chk({nm, "_rst_out_valid"}, {255'h0, out_valid}, 256'h0);
        chk({nm, "_rst_out"}, {192'h0, out}, 256'h0);
        chk({nm, "_rst_in_ready"}, {255'h0, in_ready}, 256'h1);
        exp_out_q.delete();
        exp_lat_q.delete();
        t0_q.delete();
        name_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]  p1, p2, ct1, ct2, kat;
        logic [255:0] ka, kb, kc;
        int           n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mode = 1'b0;
        inp = '0;
        key = '0;
        p1 = 64'h1122334455667788;
        p2 = 64'hfedcba9876543210;
        ka = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        kb = 256'hdeadbeef0badf00dcafebabe123456789abcdef00fedcba987654321a5a5c3c3;
        kc = 256'h5555aaaa33331111777799990000ffff1234123456785678abcdabcdef01ef01;
        kat = model(64'h0123456789abcdef, 256'h0, 1'b0);
        ct1 = model(p1, ka, 1'b0);
        ct2 = model(p2, kb, 1'b0);

        #1 rst = 1'b1;
        #1;
        chk("reset_out_valid", {255'h0, out_valid}, 256'h0);
        chk("reset_in_ready", {255'h0, in_ready}, 256'h1);
        chk("reset_out", {192'h0, out}, 256'h0);
        chk("model_roundtrip", {192'h0, model(ct1, ka, 1'b1)}, {192'h0, p1});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 64'h0123456789abcdef, 256'h0, kat, H, "kat");
        wait_done("kat");

        issue(1'b0, p1, ka, ct1, H, "rt_enc");
        wait_done("rt_enc");
        issue(1'b1, ct1, ka, p1, 2 * H, "rt_dec_miss");
        wait_done("rt_dec_miss");
        issue(1'b1, ct1, ka, p1, H, "rt_dec_hit");
        wait_done("rt_dec_hit");

        issue(1'b1, ct2, kb, p2, 2 * H, "inval_dec_b_miss");
        wait_done("inval_dec_b_miss");
        issue(1'b1, ct2, kb, p2, H, "inval_dec_b_hit");
        wait_done("inval_dec_b_hit");

        out_ready = 1'b0;
        issue(1'b0, p2, kb, ct2, H, "bp_enc");
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("bp_valid_timeout", 256'h0, 256'h1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("bp_out_stable", {192'h0, out}, {192'h0, ct2});
            chk("bp_in_ready_low", {255'h0, in_ready}, 256'h0);
            chk("bp_out_valid_high", {255'h0, out_valid}, 256'h1);
            in_valid = (i % 2 == 0);
            mode = 1'b1;
            inp = 64'(i) * 64'h0101010101010101;
            key = ka;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", {255'h0, in_ready}, 256'h1);
        chk("bp_release_out_valid", {255'h0, out_valid}, 256'h0);
        // Ignored requests must not have touched the key cache.
        issue(1'b1, ct2, kb, p2, H, "bp_after_dec_hit");
        wait_done("bp_after_dec_hit");

        issue(1'b1, ct1, kc, 64'h0, 0, "abort_precomp");
        repeat (40) @(negedge clk);
        reset_mid("precomp");
        issue(1'b0, p1, ka, 64'h0, 0, "abort_run");
        repeat (60) @(negedge clk);
        reset_mid("run");
        issue(1'b1, ct2, kb, p2, 2 * H, "post_reset_dec_miss");
        wait_done("post_reset_dec_miss");
        issue(1'b1, ct2, kb, p2, H, "post_reset_dec_hit");
        wait_done("post_reset_dec_hit");

        repeat (3) @(negedge clk);
        if (exp_out_q.size() != 0) chk("scoreboard_drained", 256'(exp_out_q.size()), 256'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
